sine_duty_gen: RTL



---
 rtl/sine_duty_gen_if.sv | 23 ++
 rtl/sine_duty_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sine_duty_gen_if.sv
// Bundle between the PWM tick domain logic and the sine duty generator.
// master: drives en, tick, phase_inc; slave: returns width, width_valid, wrap.
interface sine_duty_gen_if #(
    parameter int PHASE_W = 32,
    parameter int WIDTH_W = 32
);
    logic               en;
    logic               tick;
    logic [PHASE_W-1:0] phase_inc;
    logic [WIDTH_W-1:0] width;
    logic               width_valid;
    logic               wrap;

    modport master (
        output en, tick, phase_inc,
        input  width, width_valid, wrap
    );

    modport slave (
        input  en, tick, phase_inc,
        output width, width_valid, wrap
    );
endinterface

// File: rtl/sine_duty_gen.sv
// DDS sine duty-width generator: one double-buffered PWM width per tick.
// Ports: clk, rst (sync, active-high), bus (slave: en/tick/phase_inc in, width/width_valid/wrap out).
module sine_duty_gen #(
    parameter int PERIOD  = 1000,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int AMP_W   = 16,
    parameter int WIDTH_W = 32
) (
    input logic            clk,
    input logic            rst,
    sine_duty_gen_if.slave bus
);

    localparam int                 QW       = 2 ** LUT_AW;
    localparam logic [WIDTH_W-1:0] HALF     = WIDTH_W'(PERIOD / 2);
    localparam logic [WIDTH_W-1:0] PERIOD_L = WIDTH_W'(PERIOD);
    localparam logic [AMP_W-1:0]   MID      = {1'b1, {(AMP_W-1){1'b0}}};

    // Quarter-wave entry, sampled half a step into each bin so that
    // mirroring around pi/2 maps bin i exactly onto bin QW-1-i.
    function automatic logic [AMP_W-2:0] lut_val(input int i);
        real x;
        real s;
        x = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(QW);
        s = real'((2 ** (AMP_W - 1)) - 1) * $sin(x);
        return (AMP_W-1)'($rtoi(s + 0.5));
    endfunction

    logic [AMP_W-2:0] lut_rom [QW];

    for (genvar gi = 0; gi < QW; gi++) begin : g_lut
        localparam logic [AMP_W-2:0] V = lut_val(gi);
        assign lut_rom[gi] = V;
    end

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               s1_v_q, s1_v_d;
    logic [LUT_AW-1:0]  s1_idx_q, s1_idx_d;
    logic               s1_neg_q, s1_neg_d;
    logic               s2_v_q, s2_v_d;
    logic [AMP_W-2:0]   s2_mag_q, s2_mag_d;
    logic               s2_neg_q, s2_neg_d;
    logic               s3_v_q, s3_v_d;
    logic [AMP_W-1:0]   s3_u_q, s3_u_d;
    logic [WIDTH_W-1:0] pending_q, pending_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic               width_valid_q, width_valid_d;
    logic               wrap_q, wrap_d;

    logic               launch;
    logic               carry;
    logic [PHASE_W-1:0] sum;
    logic [1:0]         quad;
    logic [LUT_AW-1:0]  addr;
    logic [WIDTH_W-1:0] scaled;

    always_comb begin
        launch        = bus.tick & bus.en;
        {carry, sum}  = {1'b0, phase_q} + {1'b0, bus.phase_inc};
        quad          = phase_q[PHASE_W-1 -: 2];
        addr          = phase_q[PHASE_W-3 -: LUT_AW];

        phase_d       = phase_q;
        pending_d     = pending_q;
        width_d       = width_q;
        width_valid_d = 1'b0;
        wrap_d        = 1'b0;

        // S1: fold phase into a quarter-wave index and a sign
        s1_v_d   = launch;
        s1_idx_d = quad[0] ? ~addr : addr;
        s1_neg_d = quad[1];

        // S2: registered ROM read
        s2_v_d   = s1_v_q;
        s2_mag_d = lut_rom[s1_idx_q];
        s2_neg_d = s1_neg_q;

        // S3: offset-binary sample, always within [1, 2^AMP_W-1]
        s3_v_d = s2_v_q;
        s3_u_d = s2_neg_q ? MID - {1'b0, s2_mag_q}
                          : MID + {1'b0, s2_mag_q};

        // S4: scale to the PWM period with a full-precision product
        scaled = WIDTH_W'(({{WIDTH_W{1'b0}}, s3_u_q} *
                           {{AMP_W{1'b0}}, PERIOD_L}) >> AMP_W);
        if (s3_v_q) begin
            pending_d = scaled;
        end

        // A disabled tick forces mid-scale even over a late completion
        if (bus.tick) begin
            width_valid_d = 1'b1;
            if (bus.en) begin
                width_d = pending_q;
                phase_d = sum;
                wrap_d  = carry;
            end else begin
                width_d   = HALF;
                pending_d = HALF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= '0;
            s1_v_q        <= 1'b0;
            s1_idx_q      <= '0;
            s1_neg_q      <= 1'b0;
            s2_v_q        <= 1'b0;
            s2_mag_q      <= '0;
            s2_neg_q      <= 1'b0;
            s3_v_q        <= 1'b0;
            s3_u_q        <= '0;
            pending_q     <= HALF;
            width_q       <= HALF;
            width_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            s1_v_q        <= s1_v_d;
            s1_idx_q      <= s1_idx_d;
            s1_neg_q      <= s1_neg_d;
            s2_v_q        <= s2_v_d;
            s2_mag_q      <= s2_mag_d;
            s2_neg_q      <= s2_neg_d;
            s3_v_q        <= s3_v_d;
            s3_u_q        <= s3_u_d;
            pending_q     <= pending_d;
            width_q       <= width_d;
            width_valid_q <= width_valid_d;
            wrap_q        <= wrap_d;
        end
    end

    assign bus.width       = width_q;
    assign bus.width_valid = width_valid_q;
    assign bus.wrap        = wrap_q;

endmodule
